mem_bus_responder: RTL and testbench

//  Memory-side responder for the CPU control FSM's rd/wr strobes.

---
 rtl/mem_bus_responder_if.sv | 25 ++
 rtl/mem_bus_responder.sv | 152 +++++++++++++++
 tb/tb_mem_bus_responder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_responder_if.sv
// CPU <-> memory responder bus: address, rd/wr strobes, write data, and registered read return.
// master = CPU side driving strobes; slave = responder driving data_out/data_oe/busy/wr_err.
interface mem_bus_responder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              busy;
    logic              wr_err;

    modport master (
        output addr, rd, wr, data_in,
        input  data_out, data_oe, busy, wr_err
    );

    modport slave (
        input  addr, rd, wr, data_in,
        output data_out, data_oe, busy, wr_err
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder for CPU rd/wr strobes: 2**ADDR_W x DATA_W RAM behind a one-entry posted write buffer.
// Latency: accepted read to data_oe = READ_LAT cycles; wr strobe to RAM update = 2 edges.
// Backpressure: none, strobes are never stalled and busy is informational. MEM_WPROT_EN write-protects addr < ROM_TOP.
module mem_bus_responder #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1,
    parameter int ROM_TOP  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    if (READ_LAT < 1 || READ_LAT > 7) begin : g_lat_chk
        $error("mem_bus_responder: READ_LAT must be 1..7");
    end
    if (ROM_TOP < 0 || ROM_TOP > DEPTH) begin : g_rom_chk
        $error("mem_bus_responder: ROM_TOP must be 0..2**ADDR_W");
    end

    typedef enum logic [1:0] {IDLE, RD_LAT, RD_DRV, WR_COMMIT} state_t;

    // With a single-cycle latency the count phase is skipped entirely.
    localparam state_t RD_FIRST = (READ_LAT == 1) ? RD_DRV : RD_LAT;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_dat_q, buf_dat_d;
    logic              mem_we;
    logic              drive;
    logic              busy_d;
    logic              wr_prot;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] data_out_q;
    logic              data_oe_q;
    logic              busy_q;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef MEM_WPROT_EN
    localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W+1)'(ROM_TOP);
    assign wr_prot = ({1'b0, bus.addr} < ROM_LIMIT);
`else
    assign wr_prot = 1'b0;
`endif

    // A pending buffered write shadows the RAM word it targets.
    assign rd_word = (buf_vld_q && (buf_addr_q == rd_addr_q)) ? buf_dat_q : mem[rd_addr_q];

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        cnt_d      = cnt_q;
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_dat_d  = buf_dat_q;
        mem_we     = 1'b0;
        drive      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wr) begin
                    state_d = WR_COMMIT;
                    if (!wr_prot) begin
                        buf_vld_d  = 1'b1;
                        buf_addr_d = bus.addr;
                        buf_dat_d  = bus.data_in;
                    end
                end else if (bus.rd) begin
                    rd_addr_d = bus.addr;
                    cnt_d     = LAT_M1;
                    state_d   = RD_FIRST;
                end
            end
            RD_LAT: begin
                if (!bus.rd) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = RD_DRV;
                end
            end
            RD_DRV: begin
                if (!bus.rd) begin
                    state_d = IDLE;
                end else if (bus.addr != rd_addr_q) begin
                    rd_addr_d = bus.addr;
                    cnt_d     = LAT_M1;
                    state_d   = RD_FIRST;
                end else begin
                    drive = 1'b1;
                end
            end
            WR_COMMIT: begin
                mem_we    = buf_vld_q;
                buf_vld_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RD_LAT) || (state_d == WR_COMMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            cnt_q      <= '0;
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_dat_q  <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            cnt_q      <= cnt_d;
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_dat_q  <= buf_dat_d;
            data_oe_q  <= drive;
            data_out_q <= drive ? rd_word : '0;
            busy_q     <= busy_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[buf_addr_q] <= buf_dat_q;
    end

`ifdef MEM_WPROT_EN
    logic wr_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      wr_err_q <= 1'b0;
        else if (state_q == IDLE && bus.wr && wr_prot)  wr_err_q <= 1'b1;
    end
    assign bus.wr_err = wr_err_q;
`else
    assign bus.wr_err = 1'b0;
`endif

    assign bus.data_out = data_out_q;
    assign bus.data_oe  = data_oe_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder against a transaction-level RAM/timing model.
// Build with +define+MEM_WPROT_EN to exercise the write-protect variant.
module tb_mem_bus_responder;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 8;
    localparam int READ_LAT = 3;
    localparam int ROM_TOP  = 8;
    localparam int DEPTH    = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .ROM_TOP(ROM_TOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                known   [DEPTH];
    bit                ref_err;
    int                vectors = 0;
    int                miscompares = 0;

    function automatic bit is_prot(input logic [ADDR_W-1:0] a);
`ifdef MEM_WPROT_EN
        return int'(a) < ROM_TOP;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes with wr held n cycles: captures happen on odd edges, commits on even edges.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int n, input bit settle);
        logic [DATA_W-1:0] dj;
        bus.wr   = 1'b1;
        bus.addr = a;
        for (int j = 1; j <= n; j++) begin
            dj = (j == 1) ? d : DATA_W'($urandom);
            bus.data_in = dj;
            tick();
            if (j % 2 == 1) begin
                if (is_prot(a)) ref_err = 1'b1;
                else begin ref_mem[a] = dj; known[a] = 1'b1; end
            end
            vectors++;
            if (bus.busy !== (j % 2 == 1)) begin
                miscompares++; $display("FAIL wr_busy a=%h j=%0d: got %b want %b", a, j, bus.busy, (j % 2 == 1));
            end
            vectors++;
            if (bus.data_oe !== 1'b0) begin
                miscompares++; $display("FAIL wr_oe a=%h j=%0d: got %b want 0", a, j, bus.data_oe);
            end
            vectors++;
            if (bus.wr_err !== ref_err) begin
                miscompares++; $display("FAIL wr_err a=%h j=%0d: got %b want %b", a, j, bus.wr_err, ref_err);
            end
        end
        bus.wr = 1'b0;
        if (settle && (n % 2 == 1)) tick();
    endtask

    // Holds rd for pre+hold edges; the first pre edges are swallowed by a write commit.
    // If chg>0 the address switches to a2 after edge pre+chg, restarting the latency.
    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] a2,
                           input int chg, input int hold, input int pre,
                           output logic [DATA_W-1:0] last);
        int acc;
        bit exp_oe, exp_busy;
        logic [ADDR_W-1:0] cur;
        acc = pre + 1;
        cur = a;
        last = '0;
        bus.rd   = 1'b1;
        bus.addr = a;
        for (int j = 1; j <= pre + hold; j++) begin
            tick();
            if (chg > 0 && j == pre + chg + 1) begin acc = j; cur = a2; end
            exp_oe   = (j >= acc + READ_LAT);
            exp_busy = (j >= acc) && (j <= acc + READ_LAT - 2);
            vectors++;
            if (bus.data_oe !== exp_oe) begin
                miscompares++; $display("FAIL rd_oe a=%h j=%0d: got %b want %b", cur, j, bus.data_oe, exp_oe);
            end
            vectors++;
            if (bus.busy !== exp_busy) begin
                miscompares++; $display("FAIL rd_busy a=%h j=%0d: got %b want %b", cur, j, bus.busy, exp_busy);
            end
            if (exp_oe) begin
                last = bus.data_out;
                if (known[cur]) begin
                    vectors++;
                    if (bus.data_out !== ref_mem[cur]) begin
                        miscompares++; $display("FAIL rd_data a=%h j=%0d: got %h want %h", cur, j, bus.data_out, ref_mem[cur]);
                    end
                end
            end else begin
                vectors++;
                if (bus.data_out !== '0) begin
                    miscompares++; $display("FAIL rd_idle_data a=%h j=%0d: got %h want 00", cur, j, bus.data_out);
                end
            end
            if (chg > 0 && j == pre + chg) bus.addr = a2;
        end
        bus.rd = 1'b0;
        tick();
        vectors++;
        if (bus.data_oe !== 1'b0 || bus.data_out !== '0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_drop a=%h: got oe=%b data=%h busy=%b want 0/00/0", cur, bus.data_oe, bus.data_out, bus.busy);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        vectors++;
        if (bus.data_oe !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== '0 || bus.wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_vals: got oe=%b busy=%b data=%h err=%b want 0/0/00/0", bus.data_oe, bus.busy, bus.data_out, bus.wr_err);
        end
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < DEPTH; a++)
            if (!is_prot(ADDR_W'(a))) do_write(ADDR_W'(a), DATA_W'($urandom), 1, 1);
    endtask

    task automatic test_read();
        logic [DATA_W-1:0] last;
        if (!is_prot(5'h03)) do_write(5'h03, 8'hA5, 1, 1);
        do_read(5'h03, 5'h00, 0, READ_LAT + 3, 0, last);
        do_read(5'h1A, 5'h00, 0, READ_LAT - 1, 0, last);  // aborted during latency
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] last;
        do_write(5'h1F, 8'h3C, 1, 0);
        do_read(5'h1F, 5'h00, 0, READ_LAT + 2, 1, last);
        do_read(5'h1F, 5'h00, 0, READ_LAT + 1, 0, last);
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] last;
        bus.addr = 5'h10; bus.data_in = 8'h77; bus.rd = 1'b1; bus.wr = 1'b1;
        tick();
        ref_mem[5'h10] = 8'h77; known[5'h10] = 1'b1;
        vectors++;
        if (bus.busy !== 1'b1 || bus.data_oe !== 1'b0) begin
            miscompares++; $display("FAIL collision_take: got busy=%b oe=%b want 1/0", bus.busy, bus.data_oe);
        end
        bus.rd = 1'b0; bus.wr = 1'b0;
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.data_oe !== 1'b0) begin
            miscompares++; $display("FAIL collision_commit: got busy=%b oe=%b want 0/0", bus.busy, bus.data_oe);
        end
        do_read(5'h10, 5'h00, 0, READ_LAT + 1, 0, last);
    endtask

    task automatic test_addr_change();
        logic [DATA_W-1:0] last;
        logic [ADDR_W-1:0] a1, a2;
        a1 = is_prot(5'h01) ? 5'h11 : 5'h01;
        a2 = is_prot(5'h02) ? 5'h12 : 5'h02;
        do_write(a1, 8'h11, 1, 1);
        do_write(a2, 8'h22, 1, 1);
        do_read(a1, a2, READ_LAT + 2, 2 * READ_LAT + 5, 0, last);
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] last;
        do_write(5'h0C, 8'h96, 4, 1);
        do_read(5'h0C, 5'h00, 0, READ_LAT + 1, 0, last);
        do_write(5'h1C, 8'h69, 3, 1);
        do_read(5'h1C, 5'h00, 0, READ_LAT + 1, 0, last);
    endtask

    task automatic test_wprot();
        logic [DATA_W-1:0] last;
        do_write(5'h04, 8'hFF, 1, 1);
        do_read(5'h04, 5'h00, 0, READ_LAT + 1, 0, last);
`ifdef MEM_WPROT_EN
        vectors++;
        if (last === 8'hFF) begin
            miscompares++; $display("FAIL wprot_ram4: got %h want not FF", last);
        end
`endif
        do_write(5'h08, 8'hFF, 1, 1);
        do_read(5'h08, 5'h00, 0, READ_LAT + 1, 0, last);
        vectors++;
        if (bus.wr_err !== ref_err) begin
            miscompares++; $display("FAIL wprot_sticky: got %b want %b", bus.wr_err, ref_err);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a, a2;
        logic [DATA_W-1:0] d, last;
        int hold, chg;
        for (int i = 0; i < 60; i++) begin
            a = ADDR_W'($urandom);
            d = DATA_W'($urandom);
            case ($urandom_range(0, 3))
                0, 1: do_write(a, d, $urandom_range(1, 3), 1);
                2: begin
                    hold = $urandom_range(1, 9);
                    chg  = 0;
                    if (hold >= READ_LAT + 2 && $urandom_range(0, 1) == 1)
                        chg = $urandom_range(READ_LAT, hold - 1);
                    a2 = a ^ ADDR_W'($urandom_range(1, DEPTH - 1));
                    do_read(a, a2, chg, hold, 0, last);
                end
                default: begin
                    do_write(a, d, 1, 0);
                    do_read(($urandom_range(0, 1) == 1) ? a : ADDR_W'($urandom), 5'h00, 0,
                            $urandom_range(1, 6), 1, last);
                end
            endcase
        end
    endtask

    task automatic test_reset_midop();
        logic [DATA_W-1:0] last;
        do_write(5'h15, 8'h5A, 1, 1);
        bus.addr = 5'h03; bus.rd = 1'b1;
        repeat (2) tick();
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++; $display("FAIL midlat_busy: got %b want 1", bus.busy);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.data_oe !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== '0) begin
            miscompares++; $display("FAIL midlat_reset: got oe=%b busy=%b data=%h want 0/0/00", bus.data_oe, bus.busy, bus.data_out);
        end
        bus.rd = 1'b0; ref_err = 1'b0;
        tick(); rst_n = 1'b1; tick();

        bus.addr = 5'h15; bus.rd = 1'b1;
        repeat (READ_LAT + 1) tick();
        vectors++;
        if (bus.data_oe !== 1'b1 || bus.data_out !== 8'h5A) begin
            miscompares++; $display("FAIL middrv_pre: got oe=%b data=%h want 1/5a", bus.data_oe, bus.data_out);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.data_oe !== 1'b0 || bus.data_out !== '0) begin
            miscompares++; $display("FAIL middrv_reset: got oe=%b data=%h want 0/00", bus.data_oe, bus.data_out);
        end
        bus.rd = 1'b0;
        tick(); rst_n = 1'b1; tick();

        // A write captured but not yet committed is lost on reset.
        do_write(5'h16, 8'h3D, 1, 1);
        bus.addr = 5'h16; bus.data_in = 8'hC3; bus.wr = 1'b1;
        tick();
        bus.wr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.wr_err !== 1'b0) begin
            miscompares++; $display("FAIL wrbuf_reset: got busy=%b err=%b want 0/0", bus.busy, bus.wr_err);
        end
        tick(); rst_n = 1'b1; tick();
        do_read(5'h16, 5'h00, 0, READ_LAT + 1, 0, last);
        do_read(5'h15, 5'h00, 0, READ_LAT + 1, 0, last);
    endtask

    initial begin
        bus.addr = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.data_in = '0;
        ref_err = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin ref_mem[a] = '0; known[a] = 1'b0; end
        test_reset();
        test_read();
        test_write_read();
        test_collision();
        test_addr_change();
        test_back_to_back();
        test_wprot();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
